// File: rtl/solver_sequencer.sv
// solver_sequencer: limb-serial control FSM driving one fractal solver datapath (z=f(z)+c).
module solver_sequencer #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int ITER_BITS = 16,
    parameter int FLUSH_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic cfg_limbs_en,
    input  logic [LIMB_INDEX_BITS-1:0] cfg_limbs,
    input  logic cfg_lim_en,
    input  logic [ITER_BITS-1:0] cfg_lim,
    input  logic cfg_mode_en,
    input  logic [1:0] cfg_mode,
    input  logic c_wr_re,
    input  logic c_wr_im,
    input  logic [LIMB_INDEX_BITS-1:0] c_wr_ind,
    input  logic start,
    input  logic abort,
    input  logic zre_sign,
    input  logic zim_sign,
    input  logic diverged,
    output logic cre_wr_en,
    output logic cim_wr_en,
    output logic [LIMB_INDEX_BITS-1:0] c_limb_ind,
    output logic [LIMB_INDEX_BITS-1:0] zre_rd_ind,
    output logic [LIMB_INDEX_BITS-1:0] zim_rd_ind,
    output logic op_sel,
    output logic [2:0] re_part_sel,
    output logic [1:0] im_part_sel,
    output logic [1:0] re_acc_sel,
    output logic [1:0] im_acc_sel,
    output logic z_wr_en,
    output logic [LIMB_INDEX_BITS-1:0] z_wr_ind,
    output logic busy,
    output logic result_valid,
    input  logic result_ready,
    output logic [ITER_BITS-1:0] result_count
);
    localparam int LIB = LIMB_INDEX_BITS;
    localparam int CW = $clog2(FLUSH_WAIT + 2);
    localparam logic [CW-1:0] FW_C = CW'(FLUSH_WAIT);
    typedef enum logic [2:0] {IDLE, ITER, ITER_FLUSH, CHECK, SIGN, SIGN_FLUSH, DONE} state_t;
    typedef struct packed {
        logic [LIB-1:0] zre;
        logic [LIB-1:0] zim;
        logic op;
        logic [2:0] re_part;
        logic [1:0] im_part;
        logic [1:0] re_acc;
        logic [1:0] im_acc;
        logic zwe;
        logic [LIB-1:0] zwi;
    } dp_t;
    localparam dp_t DP_IDLE = '{zre: '0, zim: '0, op: 1'b0, re_part: 3'd0, im_part: 2'd0,
                                re_acc: 2'd3, im_acc: 2'd3, zwe: 1'b0, zwi: '0};
    state_t state, state_n;
    logic [LIB-1:0] num_limbs, l, l_n, p, p_n;
    logic [ITER_BITS-1:0] iter_limit, iter, iter_n, count_n;
    logic [1:0] mode, iter_acc;
    logic flip, flip_n, sre, sre_n, sim, sim_n, eq, last, neg_im;
    logic [CW-1:0] cnt, cnt_n;
    dp_t dp, dp_n;
    assign cre_wr_en = c_wr_re && state == IDLE;
    assign cim_wr_en = c_wr_im && state == IDLE;
    assign c_limb_ind = c_wr_ind;
    assign {zre_rd_ind, zim_rd_ind, op_sel, re_part_sel, im_part_sel, re_acc_sel, im_acc_sel, z_wr_en, z_wr_ind} = dp;
    assign busy = state != IDLE;
    assign result_valid = state == DONE;
    assign eq = l == (p << 1);
    assign last = flip && p == (l >> 1);
    assign iter_acc = (!flip && p == '0) ? ((l == num_limbs) ? 2'd2 : 2'd1) : 2'd0;
    assign neg_im = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? ~(sre ^ sim) : (sre ^ sim);
    always_comb begin
        state_n = state;
        l_n = l;
        p_n = p;
        flip_n = flip;
        cnt_n = cnt;
        iter_n = iter;
        sre_n = sre;
        sim_n = sim;
        count_n = result_count;
        dp_n = DP_IDLE;
        case (state)
            IDLE: if (start && num_limbs != '0) begin
                state_n = ITER;
                iter_n = '0;
                sre_n = 1'b0;
                sim_n = 1'b0;
                l_n = num_limbs;
                p_n = '0;
                flip_n = 1'b0;
            end
            ITER: begin
                dp_n.zre = flip ? p : l - p;
                dp_n.zim = flip ? l - p : p;
                dp_n.re_acc = iter_acc;
                dp_n.im_acc = (flip && eq) ? 2'd3 : iter_acc;
                dp_n.re_part = (iter == '0) ? 3'd0 : eq ? (flip ? 3'd4 : 3'd3) : (flip ? 3'd2 : 3'd1);
                dp_n.im_part = (iter == '0) ? 2'd0 : neg_im ? 2'd2 : 2'd1;
                dp_n.zwe = last && l != num_limbs;
                dp_n.zwi = (last && l != num_limbs) ? l : '0;
                flip_n = !flip;
                if (last) begin
                    p_n = '0;
                    l_n = l - 1'b1;
                    if (l == '0) begin
                        state_n = ITER_FLUSH;
                        cnt_n = '0;
                    end
                end else if (flip) p_n = p + 1'b1;
            end
            ITER_FLUSH, SIGN_FLUSH: begin
                cnt_n = cnt + 1'b1;
                if (cnt == FW_C) begin
                    state_n = (state == ITER_FLUSH) ? CHECK : ITER;
                    l_n = num_limbs;
                    p_n = '0;
                    flip_n = 1'b0;
                end
            end
            CHECK: if (diverged && iter != '0) begin
                state_n = DONE;
                count_n = iter;
            end else if (iter == iter_limit) begin
                state_n = DONE;
                count_n = '1;
            end else begin
                state_n = SIGN;
                iter_n = iter + 1'b1;
                sre_n = zre_sign;
                sim_n = zim_sign;
                l_n = num_limbs - 1'b1;
            end
            SIGN: begin
                // Conditional negation of each component so the next pass squares |z|
                dp_n.op = 1'b1;
                dp_n.zre = l;
                dp_n.zim = l;
                dp_n.zwe = 1'b1;
                dp_n.zwi = l;
                dp_n.re_acc = !sre ? 2'd0 : (l == num_limbs - 1'b1) ? 2'd1 : 2'd2;
                dp_n.im_acc = !sim ? 2'd0 : (l == num_limbs - 1'b1) ? 2'd1 : 2'd2;
                l_n = l - 1'b1;
                if (l == '0) begin
                    state_n = SIGN_FLUSH;
                    cnt_n = '0;
                end
            end
            DONE: if (result_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            dp_n = DP_IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            l <= '0;
            p <= '0;
            flip <= 1'b0;
            cnt <= '0;
            iter <= '0;
            sre <= 1'b0;
            sim <= 1'b0;
            result_count <= '0;
            dp <= '0;
            num_limbs <= '0;
            iter_limit <= '0;
            mode <= 2'd0;
        end else begin
            state <= state_n;
            l <= l_n;
            p <= p_n;
            flip <= flip_n;
            cnt <= cnt_n;
            iter <= iter_n;
            sre <= sre_n;
            sim <= sim_n;
            result_count <= count_n;
            dp <= dp_n;
            if (state == IDLE && cfg_limbs_en) num_limbs <= cfg_limbs;
            if (state == IDLE && cfg_lim_en) iter_limit <= cfg_lim;
            if (state == IDLE && cfg_mode_en) mode <= cfg_mode;
        end
    end
endmodule
